// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding
// a circular instruction queue, with redirect flush and halt gating.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_mem_q [DEPTH];
  logic [63:0]   pc_mem_q   [DEPTH];

  logic hs;
  logic push;
  logic pop;
  logic empty;

  assign hs    = (state_q == S_REQ) & mem_req_ready;
  assign empty = (count_q == '0);
  assign push  = (state_q == S_WAIT) & mem_resp_valid
               & ~redirect_valid;
  assign pop   = ~empty & inst_ready & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid && !halt && count_q < FULL)
          state_d = S_REQ;
      end
      S_REQ: begin
        if (hs)
          state_d = redirect_valid ? S_DROP : S_WAIT;
        else if (redirect_valid)
          state_d = S_IDLE;
      end
      S_WAIT: begin
        if (mem_resp_valid)
          state_d = S_IDLE;
        else if (redirect_valid)
          state_d = S_DROP;
      end
      S_DROP: begin
        if (mem_resp_valid)
          state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == S_REQ);
    fetch_idle    = (state_q == S_IDLE);
  end

  // Redirect flushes the queue and wins over any push, pop or pc step.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (hs)
      req_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~64'd3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else if (hs) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      data_mem_q[wr_ptr_q] <= mem_resp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign mem_addr   = fetch_pc_q;
  assign inst_valid = ~empty;
  assign inst_data  = empty ? '0 : data_mem_q[rd_ptr_q];
  assign inst_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h2000: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low: sampled on the clk rising edge; 0 resets the block.
REQ-005 mem_req_valid  out  1  fetch request to memory.
REQ-006 mem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 mem_addr  out  64  byte address of the requested 32-bit word.
REQ-008 mem_resp_valid  in  1  response data valid.
REQ-009 mem_resp_data  in  32  fetched instruction word.
REQ-010 inst_valid  out  1  queue head holds an instruction for decode.
REQ-011 inst_ready  in  1  decode consumes the head this cycle.
REQ-012 inst_data  out  32  head instruction.
REQ-013 inst_pc  out  64  address of the head instruction.
REQ-014 redirect_valid  in  1  branch/call/return target update; flush.
REQ-015 redirect_pc  in  64  new fetch address.
REQ-016 halt  in  1  level; blocks issue of new requests.
REQ-017 fetch_idle  out  1  high when FSM is in IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-019 IDLE->REQ when halt=0 and count<DEPTH (registered values); otherwise stay IDLE.
REQ-020 mem_req_valid SHALL be 1 exactly in REQ; mem_addr SHALL equal fetch_pc at all times and stay stable while in REQ.
REQ-021 REQ: handshake (mem_req_ready=1) -> WAIT, fetch_pc+=4, req_pc<=fetch_pc; no handshake -> stay.
REQ-022 WAIT: mem_resp_valid=1 -> push {req_pc, mem_resp_data} into queue tail, go IDLE.
REQ-023 DROP: mem_resp_valid=1 -> discard data, go IDLE; DROP exited only by a response.
REQ-024 mem_resp_valid in IDLE or REQ SHALL be ignored.
REQ-025 Redirect (highest priority): queue flushed (count=0), fetch_pc<=redirect_pc with bits[1:0] forced to 0; any same-cycle push or pop suppressed.
REQ-026 Redirect in IDLE -> IDLE; in REQ without handshake -> IDLE (request withdrawn); in REQ with handshake -> DROP; in WAIT without response -> DROP; in WAIT with response -> IDLE, response discarded; in DROP -> DROP (plus REQ-023 if response present: go IDLE).
REQ-027 Redirect SHALL NOT advance fetch_pc by 4 even if a handshake occurs that cycle.
REQ-028 inst_valid = (count!=0); inst_data/inst_pc SHALL show the head entry, 0 when empty.
REQ-029 Pop occurs when inst_valid & inst_ready & !redirect_valid; simultaneous push and pop keeps count unchanged.
REQ-030 Queue is a circular buffer; read/write pointers wrap modulo DEPTH; count range 0..DEPTH, overflow impossible by REQ-019.
REQ-031 fetch_pc arithmetic is 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+4 = 0).
REQ-032 halt asserted in REQ/WAIT SHALL NOT abort the transaction; the response is still pushed.
REQ-033 Minimum latency: reset release to first mem_req_valid 1 cycle; response to inst_valid 1 cycle.

Reset
REQ-034 reset=0 on any edge SHALL force: state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_idle=1, regardless of any in-flight request.
REQ-035 A response arriving in the first cycle after reset release SHALL be ignored.

Verification
REQ-036 Reset release, ready=1, response 1 cycle after accept with 32'hA0000001 -> mem_addr 0x2000, then inst_valid=1, inst_pc=0x2000, inst_data=32'hA0000001.
REQ-037 inst_ready=0, memory always responds -> exactly 4 entries (PCs 0x2000..0x200C) queued, fetch_idle stays 1, mem_req_valid stays 0 until a pop.
REQ-038 Redirect to 0x3006 while in WAIT -> next response discarded, next request mem_addr=0x3004, inst_valid=0 until it returns.
REQ-039 Redirect same cycle as pop with 3 queued -> count=0, no entry popped twice, next inst_pc equals the redirect target.
REQ-040 halt=1 while in WAIT -> response pushed, no further mem_req_valid until halt=0.
REQ-041 reset=0 asserted while in WAIT with 2 entries queued -> all outputs at REQ-034 values next cycle; a later response is ignored.
